// File: rtl/prbs4_pkg.sv
// Shared constants for the x^4+x^3+1 PRBS checker: LFSR geometry, taps and FSM encoding.
package prbs4_pkg;

  localparam int LFSR_W = 4;
  localparam int TAP_A  = 2;
  localparam int TAP_B  = 3;

  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] HUNT   = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  // Next stream bit predicted from a 4-bit window where bit 0 is the newest bit.
  function automatic logic lfsr_pred(input logic [LFSR_W-1:0] v);
    return v[TAP_A] ^ v[TAP_B];
  endfunction

endpackage

// File: rtl/prbs4_ref.sv
// Free-running local PRBS reference: seeded from the received history, then advanced without looking at din.
module prbs4_ref
  import prbs4_pkg::*;
(
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] load_val_i,
  input  logic              adv_i,
  output logic              pred_o
);

  logic [LFSR_W-1:0] r_q;
  logic [LFSR_W-1:0] r_d;

  assign pred_o = lfsr_pred(r_q);

  always_comb begin
    r_d = r_q;
    if (load_i) begin
      r_d = load_val_i;
    end else if (adv_i) begin
      r_d = {r_q[LFSR_W-2:0], pred_o};
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

endmodule

// File: rtl/prbs4_checker.sv
// PRBS4 stream checker: fills history, hunts for LOCK_CNT consecutive self-predicted bits,
// then compares against a free-running reference, counting errors and dropping lock on LOSS_CNT misses.
module prbs4_checker
  import prbs4_pkg::*;
#(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int SW = $clog2(LOSS_CNT + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [SW-1:0] MISS_LAST  = SW'(LOSS_CNT - 1);

  logic [1:0]        state_q, state_d;
  logic [2:0]        fill_q, fill_d;
  logic [LFSR_W-1:0] h_q, h_d, h_post;
  logic [MW-1:0]     match_q, match_d;
  logic [SW-1:0]     miss_q, miss_d;
  logic              locked_q, locked_d;
  logic              pulse_q, pulse_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ref_load, ref_adv, ref_pred;
  logic              restart;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign restart = rst | clear;
  assign h_post  = {h_q[LFSR_W-2:0], din};

  prbs4_ref u_ref (
    .clk_i      (clock),
    .clr_i      (restart),
    .load_i     (ref_load),
    .load_val_i (h_post),
    .adv_i      (ref_adv),
    .pred_o     (ref_pred)
  );

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    h_d      = h_q;
    match_d  = match_q;
    miss_d   = miss_q;
    locked_d = locked_q;
    pulse_d  = 1'b0;
    cnt_d    = cnt_q;
    ref_load = 1'b0;
    ref_adv  = 1'b0;
    if (din_valid) begin
      h_d = h_post;
      case (state_q)
        FILL: begin
          fill_d = fill_q + 3'd1;
          if (fill_q == 3'd3) begin
            state_d = HUNT;
            match_d = '0;
          end
        end
        HUNT: begin
          // A nonzero window is required so an all-zero line can never self-match.
          if ((din == lfsr_pred(h_q)) && (h_post != '0)) begin
            if (match_q == MATCH_LAST) begin
              state_d  = LOCKED;
              ref_load = 1'b1;
              locked_d = 1'b1;
              miss_d   = '0;
              match_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          ref_adv = 1'b1;
          if (din != ref_pred) begin
            pulse_d = 1'b1;
            cnt_d   = sat_inc(cnt_q);
            if (miss_q == MISS_LAST) begin
              state_d  = HUNT;
              match_d  = '0;
              miss_d   = '0;
              locked_d = 1'b0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (restart) begin
      state_q  <= FILL;
      fill_q   <= '0;
      h_q      <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      h_q      <= h_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = pulse_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_prbs4_checker.sv
// Directed bench for prbs4_checker: a 16-bit-counter instance and a 3-bit-counter instance share stimulus.
module tb_prbs4_checker;

  logic        clock = 1'b0;
  logic        rst, din, din_valid, clear;
  logic        locked_a, pulse_a;
  logic [15:0] cnt_a;
  logic        locked_b, pulse_b;
  logic [2:0]  cnt_b;

  int checks = 0;
  int failures = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  int pos = 0;
  bit ever_locked = 1'b0;
  bit seq [15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  always #5 clock = ~clock;

  prbs4_checker #(.LOCK_CNT(8), .LOSS_CNT(4), .CNT_W(16)) dut_a (
    .clock     (clock),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .clear     (clear),
    .locked    (locked_a),
    .err_pulse (pulse_a),
    .err_count (cnt_a)
  );

  prbs4_checker #(.LOCK_CNT(8), .LOSS_CNT(4), .CNT_W(3)) dut_b (
    .clock     (clock),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .clear     (clear),
    .locked    (locked_b),
    .err_pulse (pulse_b),
    .err_count (cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic v);
    @(negedge clock);
    din = b;
    din_valid = v;
    @(posedge clock);
    #1;
    pulses_a += int'(pulse_a);
    pulses_b += int'(pulse_b);
    if (locked_a) ever_locked = 1'b1;
  endtask

  task automatic send_good(input int n);
    for (int i = 0; i < n; i++) begin
      step(seq[pos], 1'b1);
      pos = (pos + 1) % 15;
    end
  endtask

  task automatic send_bad();
    step(~seq[pos], 1'b1);
    pos = (pos + 1) % 15;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; din = 1'b0; din_valid = 1'b0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("rst_locked", 32'(locked_a), 32'd0);
    check("rst_pulse", 32'(pulse_a), 32'd0);
    check("rst_count", 32'(cnt_a), 32'd0);
    check("rst_count_b", 32'(cnt_b), 32'd0);
    rst = 1'b0;

    // Clean lock: 4 fill bits plus 8 matches.
    for (int i = 1; i <= 11; i++) begin
      send_good(1);
      check($sformatf("prelock_bit%0d", i), 32'(locked_a), 32'd0);
    end
    send_good(1);
    check("lock_at_12", 32'(locked_a), 32'd1);
    check("lock_at_12_b", 32'(locked_b), 32'd1);
    pulses_a = 0;
    send_good(100);
    check("clean_pulses", 32'(pulses_a), 32'd0);
    check("clean_count", 32'(cnt_a), 32'd0);
    check("clean_locked", 32'(locked_a), 32'd1);

    // Single flipped bit.
    pulses_a = 0;
    send_bad();
    check("single_pulse", 32'(pulse_a), 32'd1);
    check("single_count", 32'(cnt_a), 32'd1);
    check("single_locked", 32'(locked_a), 32'd1);
    send_good(20);
    check("single_pulses", 32'(pulses_a), 32'd1);
    check("single_count_after", 32'(cnt_a), 32'd1);
    check("single_locked_after", 32'(locked_a), 32'd1);

    // Gap with random din while invalid.
    pulses_a = 0;
    for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), 1'b0);
    check("gap_pulses", 32'(pulses_a), 32'd0);
    check("gap_locked", 32'(locked_a), 32'd1);
    check("gap_count", 32'(cnt_a), 32'd1);
    send_good(20);
    check("gap_resume_pulses", 32'(pulses_a), 32'd0);
    check("gap_resume_count", 32'(cnt_a), 32'd1);

    // Loss of lock after 4 consecutive misses.
    pulses_a = 0;
    send_bad(); send_bad(); send_bad();
    check("loss_still_locked", 32'(locked_a), 32'd1);
    send_bad();
    check("loss_unlocked", 32'(locked_a), 32'd0);
    check("loss_count", 32'(cnt_a), 32'd5);
    check("loss_pulses", 32'(pulses_a), 32'd4);
    pulses_a = 0;
    send_good(12);
    check("relock_locked", 32'(locked_a), 32'd1);
    check("relock_count", 32'(cnt_a), 32'd5);
    check("relock_pulses", 32'(pulses_a), 32'd0);

    // Clear mid-lock with err_count=5.
    clear = 1'b1;
    step(seq[pos], 1'b1);
    clear = 1'b0;
    check("clr_locked", 32'(locked_a), 32'd0);
    check("clr_count", 32'(cnt_a), 32'd0);
    check("clr_pulse", 32'(pulse_a), 32'd0);
    check("clr_count_b", 32'(cnt_b), 32'd0);
    send_good(11);
    check("clr_prelock", 32'(locked_a), 32'd0);
    send_good(1);
    check("clr_relock", 32'(locked_a), 32'd1);

    // rst and clear together mid-lock with err_count=5.
    for (int i = 0; i < 5; i++) begin
      send_bad();
      send_good(2);
    end
    check("pre_rst_count", 32'(cnt_a), 32'd5);
    check("pre_rst_locked", 32'(locked_a), 32'd1);
    rst = 1'b1; clear = 1'b1;
    step(seq[pos], 1'b1);
    rst = 1'b0; clear = 1'b0;
    check("rstclr_locked", 32'(locked_a), 32'd0);
    check("rstclr_count", 32'(cnt_a), 32'd0);
    send_good(11);
    check("rstclr_prelock", 32'(locked_a), 32'd0);
    send_good(1);
    check("rstclr_relock", 32'(locked_a), 32'd1);

    // Saturation on the 3-bit counter instance.
    pulses_b = 0;
    for (int i = 0; i < 7; i++) begin
      send_bad();
      send_good(2);
    end
    check("sat_at7", 32'(cnt_b), 32'd7);
    for (int i = 0; i < 3; i++) begin
      send_bad();
      check($sformatf("sat_pulse%0d", i + 8), 32'(pulse_b), 32'd1);
      send_good(2);
    end
    check("sat_hold", 32'(cnt_b), 32'd7);
    check("sat_pulses", 32'(pulses_b), 32'd10);
    check("sat_locked_b", 32'(locked_b), 32'd1);
    check("sat_count_a", 32'(cnt_a), 32'd10);

    // All-zero line can never lock.
    rst = 1'b1;
    step(1'b0, 1'b1);
    rst = 1'b0;
    ever_locked = 1'b0;
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1);
    check("zeros_never_locked", 32'(ever_locked), 32'd0);
    check("zeros_count", 32'(cnt_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
